rr_lock_arbiter: RTL
====================

Name: rr_lock_arbiter

Overview:
- Sequential round-robin arbiter with grant locking. It shares one resource (e.g. a single Add/LUT datapath) among N requesters.
- The winner holds the grant until it releases. Priority then rotates to the requester after the last winner.
- The combinational core is a masked lowest-set-bit isolate (req & ~(req-1)); this block wraps it with state, a rotating pointer and handshake.
- Sits between requester ports and the shared datapath's operand mux select.

Parameters:
- N, 4, number of requesters (2..16)
- IDX_W, clog2(N), width of grant index
- TIMEOUT, 15, max cycles a grant may be held; used only when ARB_TIMEOUT_EN is defined

Ports:
- CLK  input  1  clock, rising edge
- ASYNCRESET  input  1  asynchronous, active-high reset
- req  input  N  per-requester request, level-sensitive
- release  input  N  per-requester release strobe; only the bit of the current owner is honoured
- grant  output  N  one-hot grant, registered
- grant_valid  output  1  OR of grant, registered
- grant_idx  output  IDX_W  binary index of owner, registered; 0 when idle
- timeout  output  1  one-cycle pulse when a grant is revoked; exists only with ARB_TIMEOUT_EN

Behaviour:
- Reset (async assert, sync-to-CLK deassert is external):
  - grant=0, grant_valid=0, grant_idx=0, ptr=0, state=IDLE, timeout=0.
- State IDLE:
  - If req!=0, the winner is registered at the next CLK edge; state goes to BUSY.
  - Latency from req high to grant high is 1 cycle.
- Winner selection:
  - masked = req & {bits i >= ptr}.
  - If masked!=0, winner = lowest set bit of masked; else winner = lowest set bit of req.
- Pointer update on every new grant: ptr <= (winner+1) mod N; wraps N-1 -> 0.
- State BUSY, owner o. A release event is release[o]=1 or req[o]=0.
  - No release event: grant is held unchanged. Requests from others are ignored; no preemption.
  - Release event and other req bits set (req[o] excluded): direct handoff at the same edge to a new winner, computed with the updated ptr. No idle cycle between grants.
  - Release event and no other requests: grant clears and state goes to IDLE.
  - The owner's own req in its release cycle is masked out. This prevents immediate re-grant to the same requester when others wait. If it is the only requester it is re-granted one cycle later via IDLE.
- release bits of non-owners have no effect.
- Simultaneous requests: resolved by the rotating pointer, so every requester wins within N grants (starvation-free).
- Invariant: grant is always zero or one-hot; grant_valid == |grant.
- Reset asserted mid-grant: outputs clear immediately, asynchronously. ptr returns to 0.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An internal hold counter (width clog2(TIMEOUT+1)) clears on each new grant and increments each BUSY cycle.
  - When the counter reaches TIMEOUT with no release event, the grant is revoked as if released: handoff or IDLE by the same rules.
  - timeout pulses high for that one cycle.
  - The revoked owner's req is masked for that selection.
- Not defined:
  - No counter, no timeout port.
  - A grant is held indefinitely until a release event.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> grant=0, grant_valid=0, grant_idx=0 throughout.
- req=4'b1010 from idle -> next edge grant=4'b0010, grant_idx=1, ptr=2. Hold 3 cycles, then release[1]=1 -> same edge grant=4'b1000, grant_idx=3, ptr=0.
- req=4'b1111 held, each owner releases after 1 cycle -> grant sequence 0001,0010,0100,1000,0001 with no gap cycles. Verifies the wrap 3->0.
- Owner 2 drops req[2] while req=4'b0000 otherwise -> next edge grant=0, grant_valid=0. Then req[2]=1 again -> re-granted 1 cycle later.
- ASYNCRESET pulsed mid-cycle while grant=4'b0100 -> grant=0 before the next CLK edge. After reset, req=4'b0100 -> grant_idx=2, ptr=3.
- ARB_TIMEOUT_EN, TIMEOUT=3, req=4'b0011, owner 0 never releases -> after 3 BUSY cycles timeout=1 for one cycle and grant=4'b0010. Without the macro, grant=4'b0001 stays for 20+ cycles.

Source files
------------

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter whose winner keeps the grant until it releases; priority rotates past the last winner.
// Define ARB_TIMEOUT_EN to revoke grants held for TIMEOUT cycles and expose the timeout pulse.
module rr_lock_arbiter #(
    parameter int N       = 4,
    parameter int IDX_W   = $clog2(N),
    parameter int TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [N-1:0]     req,
    // "release" is a reserved word in SystemVerilog, so the release strobes are named rel
    input  logic [N-1:0]     rel,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
`ifdef ARB_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     cand;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             rel_evt;
    logic             drop;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             expire;

    assign expire  = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign drop    = rel_evt | expire;
    assign timeout = tmo_q;
`else
    assign drop    = rel_evt;
`endif

    // The current owner is excluded so a releasing owner cannot win its own handoff
    always_comb begin
        cand      = req & ~grant_q;
        win_found = |cand;
        win_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) win_idx = IDX_W'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i] && (i >= int'(ptr_q))) win_idx = IDX_W'(i);
        end
    end

    assign rel_evt = |(grant_q & (rel | ~req));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = expire & ~rel_evt;
`endif
        if ((state_q == IDLE) || drop) begin
            if (win_found) begin
                state_d          = BUSY;
                grant_d          = '0;
                grant_d[win_idx] = 1'b1;
                idx_d            = win_idx;
                ptr_d            = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
`ifdef ARB_TIMEOUT_EN
                cnt_d            = '0;
`endif
            end else begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
            end
        end else begin
`ifdef ARB_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
        end
        valid_d = |grant_d;
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;

endmodule
